reservation_station: RTL

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station_pkg.sv | 19 +
 rtl/reservation_station_if.sv | 52 +++++
 rtl/reservation_station_rs_slot.sv | 83 ++++++++
 rtl/reservation_station.sv | 138 +++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared core definitions: reservation-station slot states and ALU op-type codes.
package reservation_station_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WAITING = 2'd1,
        READY   = 2'd2
    } slot_state_e;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_AND = 8'h02;
    localparam logic [7:0] OP_OR  = 8'h03;
    localparam logic [7:0] OP_XOR = 8'h04;
    localparam logic [7:0] OP_SLL = 8'h05;
    localparam logic [7:0] OP_SRL = 8'h06;
    localparam logic [7:0] OP_SRA = 8'h07;

endpackage

// File: rtl/reservation_station_if.sv
// Issue, forwarding, CDB, dispatch and flush signals of the reservation station.
interface reservation_station_if #(
    parameter int XLEN                = 64,
    parameter int DECODED_INSTR_WIDTH = 8,
    parameter int ROB_INDEX_WIDTH     = 8
);
    logic                           issue_valid;
    logic                           issue_ready;
    logic [DECODED_INSTR_WIDTH-1:0] issue_decoded_instruction;
    logic [XLEN-1:0]                issue_rs1_data_or_ROB;
    logic                           issue_rs1_is_renamed;
    logic [XLEN-1:0]                issue_rs2_data_or_ROB;
    logic                           issue_rs2_is_renamed;
    logic [XLEN-1:0]                issue_address;
    logic [ROB_INDEX_WIDTH-1:0]     issue_ROB_index;
    logic                           forward_response_valid_1;
    logic [XLEN-1:0]                forward_response_data_1;
    logic                           forward_response_valid_2;
    logic [XLEN-1:0]                forward_response_data_2;
    logic                           cdb_valid;
    logic [ROB_INDEX_WIDTH-1:0]     cdb_ROB_index;
    logic [XLEN-1:0]                cdb_data;
    logic                           dispatch_valid;
    logic                           dispatch_ready;
    logic [DECODED_INSTR_WIDTH-1:0] dispatch_decoded_instruction;
    logic [XLEN-1:0]                dispatch_rs1_data;
    logic [XLEN-1:0]                dispatch_rs2_data;
    logic [XLEN-1:0]                dispatch_address;
    logic [ROB_INDEX_WIDTH-1:0]     dispatch_ROB_index;
    logic                           flush;

    modport master (
        output issue_valid, issue_decoded_instruction, issue_rs1_data_or_ROB, issue_rs1_is_renamed,
               issue_rs2_data_or_ROB, issue_rs2_is_renamed, issue_address, issue_ROB_index,
               forward_response_valid_1, forward_response_data_1,
               forward_response_valid_2, forward_response_data_2,
               cdb_valid, cdb_ROB_index, cdb_data, dispatch_ready, flush,
        input  issue_ready, dispatch_valid, dispatch_decoded_instruction, dispatch_rs1_data,
               dispatch_rs2_data, dispatch_address, dispatch_ROB_index
    );

    modport slave (
        input  issue_valid, issue_decoded_instruction, issue_rs1_data_or_ROB, issue_rs1_is_renamed,
               issue_rs2_data_or_ROB, issue_rs2_is_renamed, issue_address, issue_ROB_index,
               forward_response_valid_1, forward_response_data_1,
               forward_response_valid_2, forward_response_data_2,
               cdb_valid, cdb_ROB_index, cdb_data, dispatch_ready, flush,
        output issue_ready, dispatch_valid, dispatch_decoded_instruction, dispatch_rs1_data,
               dispatch_rs2_data, dispatch_address, dispatch_ROB_index
    );

endinterface

// File: rtl/reservation_station_rs_slot.sv
// One reservation-station entry: operand storage plus CDB wakeup of pending tags.
module rs_slot
    import reservation_station_pkg::*;
#(
    parameter int XLEN                = 64,
    parameter int DECODED_INSTR_WIDTH = 8,
    parameter int ROB_INDEX_WIDTH     = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           write_en,
    input  logic                           release_en,
    input  logic [DECODED_INSTR_WIDTH-1:0] write_op,
    input  logic [XLEN-1:0]                write_rs1,
    input  logic                           write_rs1_pending,
    input  logic [XLEN-1:0]                write_rs2,
    input  logic                           write_rs2_pending,
    input  logic [XLEN-1:0]                write_address,
    input  logic [ROB_INDEX_WIDTH-1:0]     write_rob,
    input  logic                           cdb_valid,
    input  logic [ROB_INDEX_WIDTH-1:0]     cdb_rob_index,
    input  logic [XLEN-1:0]                cdb_data,
    output slot_state_e                    state,
    output logic [DECODED_INSTR_WIDTH-1:0] op,
    output logic [XLEN-1:0]                rs1_data,
    output logic [XLEN-1:0]                rs2_data,
    output logic [XLEN-1:0]                address,
    output logic [ROB_INDEX_WIDTH-1:0]     rob_index
);

    logic rs1_pending;
    logic rs2_pending;
    logic rs1_hit;
    logic rs2_hit;

    // A pending operand keeps its tag in the low bits of the data field.
    assign rs1_hit = cdb_valid && (state == WAITING) && rs1_pending
                     && (rs1_data[ROB_INDEX_WIDTH-1:0] == cdb_rob_index);
    assign rs2_hit = cdb_valid && (state == WAITING) && rs2_pending
                     && (rs2_data[ROB_INDEX_WIDTH-1:0] == cdb_rob_index);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= FREE;
            rs1_pending <= 1'b0;
            rs2_pending <= 1'b0;
            op          <= '0;
            rs1_data    <= '0;
            rs2_data    <= '0;
            address     <= '0;
            rob_index   <= '0;
        end else if (flush) begin
            state       <= FREE;
            rs1_pending <= 1'b0;
            rs2_pending <= 1'b0;
        end else if (write_en) begin
            state       <= (write_rs1_pending || write_rs2_pending) ? WAITING : READY;
            rs1_pending <= write_rs1_pending;
            rs2_pending <= write_rs2_pending;
            op          <= write_op;
            rs1_data    <= write_rs1;
            rs2_data    <= write_rs2;
            address     <= write_address;
            rob_index   <= write_rob;
        end else if (release_en) begin
            state <= FREE;
        end else if (rs1_hit || rs2_hit) begin
            if (rs1_hit) begin
                rs1_data    <= cdb_data;
                rs1_pending <= 1'b0;
            end
            if (rs2_hit) begin
                rs2_data    <= cdb_data;
                rs2_pending <= 1'b0;
            end
            if (!((rs1_pending && !rs1_hit) || (rs2_pending && !rs2_hit))) begin
                state <= READY;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station top: operand resolution at issue, free/ready priority encoders, dispatch mux.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int XLEN                = 64,
    parameter int DECODED_INSTR_WIDTH = 8,
    parameter int ROB_INDEX_WIDTH     = 8,
    parameter int RS_DEPTH            = 4,
    parameter int RS_INDEX_WIDTH      = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    reservation_station_if.slave  bus
);

    slot_state_e                    slot_state   [RS_DEPTH];
    logic [DECODED_INSTR_WIDTH-1:0] slot_op      [RS_DEPTH];
    logic [XLEN-1:0]                slot_rs1     [RS_DEPTH];
    logic [XLEN-1:0]                slot_rs2     [RS_DEPTH];
    logic [XLEN-1:0]                slot_address [RS_DEPTH];
    logic [ROB_INDEX_WIDTH-1:0]     slot_rob     [RS_DEPTH];

    logic [XLEN-1:0]           rs1_value, rs2_value;
    logic                      rs1_pending, rs2_pending;
    logic                      any_free, any_ready;
    logic [RS_INDEX_WIDTH-1:0] free_idx, ready_idx, sel_idx;
    logic                      hold_valid;
    logic [RS_INDEX_WIDTH-1:0] hold_idx;
    logic                      issue_fire, dispatch_fire;

    // Operand priority at issue: forwarded ROB value, then same-cycle CDB, else keep the tag.
    always_comb begin
        rs1_value   = bus.issue_rs1_data_or_ROB;
        rs1_pending = 1'b0;
        rs2_value   = bus.issue_rs2_data_or_ROB;
        rs2_pending = 1'b0;
        if (bus.issue_rs1_is_renamed) begin
            if (bus.forward_response_valid_1) begin
                rs1_value = bus.forward_response_data_1;
            end else if (bus.cdb_valid
                         && bus.cdb_ROB_index == bus.issue_rs1_data_or_ROB[ROB_INDEX_WIDTH-1:0]) begin
                rs1_value = bus.cdb_data;
            end else begin
                rs1_pending = 1'b1;
            end
        end
        if (bus.issue_rs2_is_renamed) begin
            if (bus.forward_response_valid_2) begin
                rs2_value = bus.forward_response_data_2;
            end else if (bus.cdb_valid
                         && bus.cdb_ROB_index == bus.issue_rs2_data_or_ROB[ROB_INDEX_WIDTH-1:0]) begin
                rs2_value = bus.cdb_data;
            end else begin
                rs2_pending = 1'b1;
            end
        end
    end

    always_comb begin
        any_free  = 1'b0;
        free_idx  = '0;
        any_ready = 1'b0;
        ready_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (slot_state[i] == FREE) begin
                any_free = 1'b1;
                free_idx = RS_INDEX_WIDTH'(i);
            end
            if (slot_state[i] == READY) begin
                any_ready = 1'b1;
                ready_idx = RS_INDEX_WIDTH'(i);
            end
        end
    end

    // A stalled dispatch stays locked to its slot so the offered instruction cannot change under it.
    assign sel_idx            = hold_valid ? hold_idx : ready_idx;
    assign bus.issue_ready    = any_free;
    assign bus.dispatch_valid = any_ready && !bus.flush;
    assign issue_fire         = bus.issue_valid && any_free && !bus.flush;
    assign dispatch_fire      = bus.dispatch_valid && bus.dispatch_ready;

    always_comb begin
        bus.dispatch_decoded_instruction = '0;
        bus.dispatch_rs1_data            = '0;
        bus.dispatch_rs2_data            = '0;
        bus.dispatch_address             = '0;
        bus.dispatch_ROB_index           = '0;
        if (bus.dispatch_valid) begin
            bus.dispatch_decoded_instruction = slot_op[sel_idx];
            bus.dispatch_rs1_data            = slot_rs1[sel_idx];
            bus.dispatch_rs2_data            = slot_rs2[sel_idx];
            bus.dispatch_address             = slot_address[sel_idx];
            bus.dispatch_ROB_index           = slot_rob[sel_idx];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_idx   <= '0;
        end else begin
            hold_valid <= bus.dispatch_valid && !bus.dispatch_ready;
            hold_idx   <= sel_idx;
        end
    end

    for (genvar g = 0; g < RS_DEPTH; g++) begin : g_slot
        rs_slot #(
            .XLEN                (XLEN),
            .DECODED_INSTR_WIDTH (DECODED_INSTR_WIDTH),
            .ROB_INDEX_WIDTH     (ROB_INDEX_WIDTH)
        ) u_slot (
            .clock             (clock),
            .reset             (reset),
            .flush             (bus.flush),
            .write_en          (issue_fire && (free_idx == RS_INDEX_WIDTH'(g))),
            .release_en        (dispatch_fire && (sel_idx == RS_INDEX_WIDTH'(g))),
            .write_op          (bus.issue_decoded_instruction),
            .write_rs1         (rs1_value),
            .write_rs1_pending (rs1_pending),
            .write_rs2         (rs2_value),
            .write_rs2_pending (rs2_pending),
            .write_address     (bus.issue_address),
            .write_rob         (bus.issue_ROB_index),
            .cdb_valid         (bus.cdb_valid),
            .cdb_rob_index     (bus.cdb_ROB_index),
            .cdb_data          (bus.cdb_data),
            .state             (slot_state[g]),
            .op                (slot_op[g]),
            .rs1_data          (slot_rs1[g]),
            .rs2_data          (slot_rs2[g]),
            .address           (slot_address[g]),
            .rob_index         (slot_rob[g])
        );
    end

endmodule
